// File: rtl/mnacidpro_valve_sequencer.sv
// rtl/mnacidpro_valve_sequencer.sv - valve/pump sequencer for the purification run
// Optional hold/freeze support is enabled by defining MNACID_SEQ_HOLD_EN.
module mnacidpro_valve_sequencer #(
  parameter int SIZE        = 5,
  parameter int CNT_W       = 8,
  parameter int LOAD_CYC    = 16,
  parameter int LYSIS_CYC   = 32,
  parameter int WASH_CYC    = 16,
  parameter int ELUTE_CYC   = 16,
  parameter int COLLECT_CYC = 8,
  parameter int PUMP_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    hold,
  input  logic [$clog2(SIZE)-1:0] outlet,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              stage,
  output logic                    lysis_ctrl,
  output logic                    wash_ctrl,
  output logic                    elute_ctrl,
  output logic                    waste_ctrl,
  output logic                    bead_ctrl,
  output logic                    bead_trap_ctrl,
  output logic                    collect_ctrl,
  output logic [2:0]              pump,
  output logic [SIZE-1:0]         collect_sel
);

  localparam int OW = $clog2(SIZE);
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DW-1:0] DIV_M1 = DW'(PUMP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BEAD_LOAD = 3'd1,
    LYSIS     = 3'd2,
    WASH      = 3'd3,
    ELUTE     = 3'd4,
    COLLECT   = 3'd5
  } state_t;

  state_t          state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]   div;
  logic [2:0]      phase;
  logic [OW-1:0]   sel;
  logic [6:0]      valves;
  logic [SIZE-1:0] sel_onehot;
  logic            hold_act, go_idle, enter, freeze, run, finish;

`ifdef MNACID_SEQ_HOLD_EN
  assign hold_act = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign hold_act    = 1'b0;
`endif

  // Valve bit order: lysis, wash, elute, waste, bead, bead_trap, collect (1 = closed)
  assign {lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl,
          bead_ctrl, bead_trap_ctrl, collect_ctrl} = valves;
  assign stage      = state;
  assign sel_onehot = SIZE'(1) << sel;

  function automatic logic [6:0] valves_of(state_t s);
    case (s)
      BEAD_LOAD: valves_of = 7'b1110001;
      LYSIS:     valves_of = 7'b0110111;
      WASH:      valves_of = 7'b1010111;
      ELUTE:     valves_of = 7'b1101111;
      COLLECT:   valves_of = 7'b1111110;
      default:   valves_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_m1(state_t s);
    case (s)
      BEAD_LOAD: dur_m1 = CNT_W'(LOAD_CYC - 1);
      LYSIS:     dur_m1 = CNT_W'(LYSIS_CYC - 1);
      WASH:      dur_m1 = CNT_W'(WASH_CYC - 1);
      ELUTE:     dur_m1 = CNT_W'(ELUTE_CYC - 1);
      COLLECT:   dur_m1 = CNT_W'(COLLECT_CYC - 1);
      default:   dur_m1 = '0;
    endcase
  endfunction

  function automatic state_t next_of(state_t s);
    case (s)
      BEAD_LOAD: next_of = LYSIS;
      LYSIS:     next_of = WASH;
      WASH:      next_of = ELUTE;
      ELUTE:     next_of = COLLECT;
      default:   next_of = IDLE;
    endcase
  endfunction

  always_comb begin
    go_idle = 1'b0;
    enter   = 1'b0;
    freeze  = 1'b0;
    run     = 1'b0;
    finish  = 1'b0;
    nxt     = state;
    case (state)
      IDLE: if (start && (int'(outlet) < SIZE)) begin
        enter = 1'b1;
        nxt   = BEAD_LOAD;
      end
      BEAD_LOAD, LYSIS, WASH, ELUTE, COLLECT: begin
        if (abort) go_idle = 1'b1;
        else if (hold_act) freeze = 1'b1;
        else if (cnt == '0) begin
          if (state == COLLECT) begin
            go_idle = 1'b1;
            finish  = 1'b1;
          end else begin
            enter = 1'b1;
            nxt   = next_of(state);
          end
        end else run = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || go_idle) begin
      state       <= IDLE;
      valves      <= '1;
      pump        <= 3'b111;
      collect_sel <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      div         <= '0;
      phase       <= 3'b011;
      done        <= !rst && finish;
    end else begin
      done <= 1'b0;
      if (enter) begin
        state       <= nxt;
        valves      <= valves_of(nxt);
        cnt         <= dur_m1(nxt);
        div         <= DIV_M1;
        phase       <= 3'b011;
        pump        <= 3'b011;
        busy        <= 1'b1;
        collect_sel <= (nxt == COLLECT) ? sel_onehot : '0;
        if (state == IDLE) sel <= outlet;
      end else if (freeze) begin
        pump <= 3'b111;
      end else if (run) begin
        cnt <= cnt - 1'b1;
        // Rotate-left walks 011 -> 110 -> 101 -> 011
        if (div == '0) begin
          div   <= DIV_M1;
          phase <= {phase[1:0], phase[2]};
          pump  <= {phase[1:0], phase[2]};
        end else begin
          div  <= div - 1'b1;
          pump <= phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_mnacidpro_valve_sequencer.sv
// tb/tb_mnacidpro_valve_sequencer.sv - self-checking bench for mnacidpro_valve_sequencer
module tb_mnacidpro_valve_sequencer;

  localparam int SIZE = 5;
  localparam int PUMP_DIV = 4;
`ifdef MNACID_SEQ_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, hold;
  logic [2:0] outlet;
  logic busy, done;
  logic [2:0] stage, pump;
  logic lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_ctrl, bead_trap_ctrl, collect_ctrl;
  logic [SIZE-1:0] collect_sel;
  logic [6:0] valves;

  mnacidpro_valve_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold), .outlet(outlet),
    .busy(busy), .done(done), .stage(stage),
    .lysis_ctrl(lysis_ctrl), .wash_ctrl(wash_ctrl), .elute_ctrl(elute_ctrl),
    .waste_ctrl(waste_ctrl), .bead_ctrl(bead_ctrl), .bead_trap_ctrl(bead_trap_ctrl),
    .collect_ctrl(collect_ctrl), .pump(pump), .collect_sel(collect_sel)
  );

  always #5 clk = ~clk;

  assign valves = {lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_ctrl, bead_trap_ctrl, collect_ctrl};

  int errors = 0;
  int checks = 0;

  // Reference model: stage index, cycles elapsed in stage (excluding held cycles)
  int m_s = 0, m_e = 0, m_sel = 0;
  bit m_done = 0, m_held = 0;
  int dur[6] = '{0, 16, 32, 16, 16, 8};
  // Valves that are open (0) in each stage, same bit order as 'valves'
  logic [6:0] open_mask[6] = '{7'b0000000, 7'b0001110, 7'b1001000, 7'b0101000, 7'b0010000, 7'b0000001};
  logic [2:0] pat[3] = '{3'b011, 3'b110, 3'b101};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_s = 0; m_done = 0; m_held = 0;
    end else if (m_s == 0) begin
      m_done = 0; m_held = 0;
      if (start && outlet < SIZE) begin m_s = 1; m_e = 0; m_sel = outlet; end
    end else begin
      m_done = 0;
      if (abort) begin m_s = 0; m_held = 0; end
      else if (HOLD_EN && hold) m_held = 1;
      else begin
        m_held = 0;
        m_e++;
        if (m_e == dur[m_s]) begin
          if (m_s == 5) begin m_s = 0; m_done = 1; end
          else begin m_s++; m_e = 0; end
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [2:0] ep;
    logic [SIZE-1:0] es;
    ep = (m_s == 0 || m_held) ? 3'b111 : pat[(m_e / PUMP_DIV) % 3];
    es = (m_s == 5) ? SIZE'(1) << m_sel : '0;
    check("m_stage", stage, m_s);
    check("m_busy", busy, m_s != 0);
    check("m_done", done, m_done);
    check("m_valves", valves, 7'h7f & ~open_mask[m_s]);
    check("m_pump", pump, ep);
    check("m_sel", collect_sel, es);
  endtask

  task automatic tick(input logic s, input logic a, input logic h, input logic [2:0] o);
    start = s; abort = a; hold = h; outlet = o;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_stage(input int s);
    int n = 0;
    while (stage !== 3'(s) && n < 300) begin tick(0, 0, 0, 0); n++; end
    check("wait_stage", stage, s);
  endtask

  typedef struct {
    logic [2:0] outlet;
    logic       exp_busy;
    logic [2:0] exp_stage;
    logic [6:0] exp_valves;
  } vec_t;

  initial begin
    vec_t vt[8];
    int n, bad;
    bit last_hold;
    for (int i = 0; i < 8; i++) begin
      vt[i].outlet     = 3'(i);
      vt[i].exp_busy   = (i < SIZE);
      vt[i].exp_stage  = (i < SIZE) ? 3'd1 : 3'd0;
      vt[i].exp_valves = (i < SIZE) ? 7'b1110001 : 7'b1111111;
    end

    rst = 1; start = 0; abort = 0; hold = 0; outlet = 0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 0;
    check("rst_stage", stage, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valves", valves, 7'h7f);
    check("rst_pump", pump, 3'b111);
    check("rst_sel", collect_sel, 0);

    // Start acceptance per outlet, then abort back to IDLE
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, vt[i].outlet);
      check("vec_busy", busy, vt[i].exp_busy);
      check("vec_stage", stage, vt[i].exp_stage);
      check("vec_valves", valves, vt[i].exp_valves);
      tick(0, 1, 0, 0);
      check("vec_abort_busy", busy, 0);
      check("vec_abort_done", done, 0);
    end

    // Full run, outlet 3
    tick(1, 0, 0, 3);
    for (int k = 1; k <= 5; k++) begin
      n = 0; bad = 0;
      while (stage === 3'(k) && n < 200) begin
        if (collect_sel !== ((k == 5) ? 5'b01000 : 5'b00000)) bad++;
        n++;
        tick(0, 0, 0, 0);
      end
      check("stage_len", n, dur[k]);
      check("sel_during_stage", bad, 0);
    end
    check("done_pulse", done, 1);
    check("done_stage", stage, 0);
    check("done_sel", collect_sel, 0);
    tick(0, 0, 0, 0);
    check("done_single", done, 0);

    // Pump pattern in BEAD_LOAD, restart on LYSIS entry, start ignored in LYSIS
    tick(1, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (pump !== pat[(i / 4) % 3]) bad++;
      tick(0, 0, 0, 0);
    end
    check("pump_bead_load", bad, 0);
    wait_stage(2);
    check("pump_lysis_entry", pump, 3'b011);
    n = 0;
    while (stage === 3'd2 && n < 200) begin
      n++;
      tick(n == 3, 0, 0, 1);
    end
    check("lysis_len_start_ignored", n, 32);
    check("after_lysis_stage", stage, 3);
    tick(0, 1, 0, 0);

    // Abort 5 cycles into WASH
    tick(1, 0, 0, 2);
    wait_stage(3);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    check("wash_still", stage, 3);
    tick(0, 1, 0, 0);
    check("abort_stage", stage, 0);
    check("abort_valves", valves, 7'h7f);
    check("abort_pump", pump, 3'b111);
    check("abort_done", done, 0);
    tick(0, 0, 0, 0);
    check("abort_no_done", done, 0);
    tick(1, 0, 0, 1);
    check("restart_stage", stage, 1);

    // hold for 10 cycles mid-ELUTE
    wait_stage(4);
    n = 0; bad = 0; last_hold = 0;
    while (stage === 3'd4 && n < 200) begin
      n++;
      if (HOLD_EN && last_hold && (pump !== 3'b111 || valves !== 7'b1101111)) bad++;
      last_hold = (n >= 3 && n < 13);
      tick(0, 0, last_hold, 0);
    end
    check("hold_outputs", bad, 0);
    check("elute_len", n, HOLD_EN ? 26 : 16);
    wait_stage(0);

    // Randomized run against the reference model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
      compare_model();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mnacidpro_valve_sequencer.md
Name: mnacidpro_valve_sequencer

Overview:
Synchronous protocol controller directly upstream of the mnacidpro_pads chip wrapper. It drives that wrapper's ctrl-type inputs (reagent valves, trap/waste/collect valves, 3-phase peristaltic pump) through a fixed nucleic-acid purification run: bead load, lysis, wash, elute, collect. A host starts a run and selects one of SIZE collect outlets; the block sequences valves and pump phases with per-stage cycle counts.

Parameters:
SIZE, 5, number of collect outlets; width of collect_sel
CNT_W, 8, width of the stage duration counter
LOAD_CYC, 16, BEAD_LOAD duration in cycles (1..2^CNT_W)
LYSIS_CYC, 32, LYSIS duration in cycles
WASH_CYC, 16, WASH duration in cycles
ELUTE_CYC, 16, ELUTE duration in cycles
COLLECT_CYC, 8, COLLECT duration in cycles
PUMP_DIV, 4, cycles per pump phase (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE
abort  input  1  terminate the active run
hold  input  1  freeze sequencing (see Optional Feature)
outlet  input  $clog2(SIZE)  collect outlet index, latched on accepted start
busy  output  1  high in any non-IDLE state
done  output  1  one-cycle pulse when COLLECT completes
stage  output  3  current state encoding
lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl, bead_ctrl, bead_trap_ctrl, collect_ctrl  output  1 each  valve controls, 1 = closed (pressurised)
pump  output  3  peristaltic pump valve controls, 1 = closed
collect_sel  output  SIZE  one-hot outlet select, 0 outside COLLECT

Behaviour:
- Interface: one clock (clk); rst synchronous, active-high. All outputs registered.
- Reset/IDLE values: all valve ctrls 1, pump=3'b111, collect_sel=0, busy=0, done=0, stage=0.
- States/encoding: IDLE=0, BEAD_LOAD=1, LYSIS=2, WASH=3, ELUTE=4, COLLECT=5. Encodings 6/7 unused; an illegal state goes to IDLE on the next cycle.
- Accepted start: start=1 in IDLE with outlet<SIZE. The state is BEAD_LOAD on the next cycle. If outlet>=SIZE, start is ignored and the block stays in IDLE.
- Each active state lasts exactly its *_CYC cycles. The counter loads *_CYC-1 on entry and advances the state on the cycle it reads 0. Sequence: BEAD_LOAD->LYSIS->WASH->ELUTE->COLLECT->IDLE.
- done pulses in the first IDLE cycle after COLLECT.
- Open valves (0) per state; every valve not listed is 1:
  - BEAD_LOAD: bead_ctrl, bead_trap_ctrl, waste_ctrl
  - LYSIS: lysis_ctrl, waste_ctrl
  - WASH: wash_ctrl, waste_ctrl
  - ELUTE: elute_ctrl
  - COLLECT: collect_ctrl; collect_sel = one-hot of the latched outlet
- Pump: active in all non-IDLE states. Pattern 3'b011 -> 3'b110 -> 3'b101 -> repeat, advancing every PUMP_DIV cycles. The phase and divider reset to 3'b011 on every state entry.
- abort in any active state: IDLE next cycle with reset output values; done is not pulsed. abort in IDLE has no effect.
- Simultaneous events: abort takes priority over stage completion. start while busy is ignored. rst mid-run forces reset values on the next edge.

Optional Feature:
MNACID_SEQ_HOLD_EN
- Defined: while hold=1 in an active state, the stage counter, pump divider and pump phase freeze. Valve outputs keep their values, except pump is forced to 3'b111. Sequencing resumes where it stopped when hold returns to 0. abort overrides hold.
- Undefined: the hold port exists but is ignored; behaviour is as if hold=0.

Test Plan:
- rst=1 for 2 cycles -> all ctrls 1, pump=111, collect_sel=0, busy=0, stage=0.
- Defaults; start=1 for one cycle with outlet=3 -> stage sequence 1,2,3,4,5 for 16,32,16,16,8 cycles respectively. After that, one done pulse, then collect_sel=5'b01000 throughout COLLECT only.
- PUMP_DIV=4, in BEAD_LOAD -> pump = 011 x4, 110 x4, 101 x4, 011 ... Pump restarts at 011 on LYSIS entry.
- abort in WASH, 5 cycles after entry -> IDLE next cycle, all ctrls 1, no done. A following start is accepted.
- start with outlet=5 (SIZE=5) -> stays IDLE, busy=0. start pulse while in LYSIS -> ignored, timing unchanged.
- MNACID_SEQ_HOLD_EN defined; hold=1 for 10 cycles mid-ELUTE -> pump=111 and lysis/wash/waste stay 1 during hold. ELUTE total length = 16+10 cycles.
